// File: rtl/ahb_arbiter_if.sv
// ============================================================================
//  ahb_arbiter_if : request/grant and bus-status bundle of the AHB arbiter
//  Revision       : 1.0
// ============================================================================
`default_nettype none

interface ahb_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int MST_WDT   = 2
);
  logic [N_MASTERS-1:0] i_hbusreq;
  logic [N_MASTERS-1:0] i_hlock;
  logic [1:0]           i_htrans;
  logic [2:0]           i_hburst;
  logic                 i_hready;
  logic [1:0]           i_hresp;
  logic [N_MASTERS-1:0] o_hgrant;
  logic [MST_WDT-1:0]   o_hmaster;
  logic [MST_WDT-1:0]   o_hmaster_data;
  logic                 o_hmastlock;

  // Arbiter side
  modport slave (
    input  i_hbusreq, i_hlock, i_htrans, i_hburst, i_hready, i_hresp,
    output o_hgrant, o_hmaster, o_hmaster_data, o_hmastlock
  );

  // Master/fabric side
  modport master (
    output i_hbusreq, i_hlock, i_htrans, i_hburst, i_hready, i_hresp,
    input  o_hgrant, o_hmaster, o_hmaster_data, o_hmastlock
  );
endinterface

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================================
//  ahb_arbiter : round-robin AHB arbiter with fixed-burst and lock tracking
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ahb_arbiter #(
  parameter int N_MASTERS  = 4,
  parameter int DEF_MASTER = 0,
  parameter int MST_WDT    = 2
) (
  input  logic         i_hclk,
  input  logic         i_hreset_n,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0]         TR_NONSEQ = 2'd2;
  localparam logic [1:0]         TR_SEQ    = 2'd3;
  localparam logic [MST_WDT-1:0] DEF_IDX   = MST_WDT'(DEF_MASTER);

  logic [MST_WDT-1:0] gnt_q, gnt_d;
  logic [MST_WDT-1:0] ptr_q, ptr_d;
  logic [MST_WDT-1:0] hmaster_q, hmaster_data_q;
  logic               hmastlock_q;
  logic [4:0]         cnt_q, cnt_d;
  logic               beat_nonseq, beat_seq;
  logic               win, found;
  logic [MST_WDT-1:0] winner;

  // Remaining-beat counter of the owner's fixed-length burst
  always_comb begin
    beat_nonseq = bus.i_hready && (bus.i_htrans == TR_NONSEQ);
    beat_seq    = bus.i_hready && (bus.i_htrans == TR_SEQ);
    cnt_d       = cnt_q;
    if (!bus.i_hready && (bus.i_hresp != 2'b00)) begin
      cnt_d = 5'd0;
    end else if (beat_nonseq) begin
      case (bus.i_hburst)
        3'd2, 3'd3: cnt_d = 5'd3;
        3'd4, 3'd5: cnt_d = 5'd7;
        3'd6, 3'd7: cnt_d = 5'd15;
        default:    cnt_d = 5'd0;
      endcase
    end else if (beat_seq && (cnt_q != 5'd0)) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  // Window opens only once no further burst address follows this edge, so
  // the NONSEQ of a fixed burst never hands the bus away before its SEQs.
  always_comb begin
    win = bus.i_hready && !hmastlock_q && !bus.i_hlock[gnt_q] && (cnt_d == 5'd0);
  end

  always_comb begin
    int idx;
    found  = 1'b0;
    winner = DEF_IDX;
    idx    = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(ptr_q) + k) % N_MASTERS;
      if (!found && bus.i_hbusreq[idx]) begin
        found  = 1'b1;
        winner = MST_WDT'(idx);
      end
    end
  end

  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (win) begin
      gnt_d = found ? winner : DEF_IDX;
      if (found && (winner != gnt_q)) begin
        ptr_d = winner;
      end
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      gnt_q          <= DEF_IDX;
      ptr_q          <= DEF_IDX;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
      cnt_q          <= 5'd0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (bus.i_hready) begin
        hmaster_q      <= gnt_q;
        hmaster_data_q <= hmaster_q;
        hmastlock_q    <= bus.i_hlock[gnt_q];
      end
    end
  end

  always_comb begin
    bus.o_hgrant        = '0;
    bus.o_hgrant[gnt_q] = 1'b1;
  end

  assign bus.o_hmaster      = hmaster_q;
  assign bus.o_hmaster_data = hmaster_data_q;
  assign bus.o_hmastlock    = hmastlock_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
// ============================================================================
//  tb_ahb_arbiter : directed scenarios plus random traffic vs. a reference model
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_ahb_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference state: grant, pointer, address/data owners, lock, beats left
  int m_gnt, m_ptr, m_hm, m_hmd, m_rem;
  bit m_lock;

  ahb_arbiter_if #(.N_MASTERS(N), .MST_WDT(W)) bus ();

  ahb_arbiter #(.N_MASTERS(N), .DEF_MASTER(0), .MST_WDT(W)) dut (
    .i_hclk     (clk),
    .i_hreset_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int burst_beats(input logic [2:0] b);
    if (b < 3'd2) return 1;
    return 4 << ((int'(b) - 2) / 2);
  endfunction

  task automatic model_reset();
    m_gnt = 0; m_ptr = 0; m_hm = 0; m_hmd = 0; m_rem = 0; m_lock = 1'b0;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                       input logic [2:0] bst, input logic rdy, input logic [1:0] rsp);
    bus.i_hbusreq = req; bus.i_hlock = lck; bus.i_htrans = tr;
    bus.i_hburst  = bst; bus.i_hready = rdy; bus.i_hresp = rsp;
  endtask

  // One clock: predict from the pre-edge inputs, then move to edge+1
  task automatic tick();
    int n_rem, n_gnt, n_ptr, n_hm, n_hmd, c;
    bit open, found, n_lock;
    n_rem = m_rem;
    if (!bus.i_hready && bus.i_hresp != 2'd0) n_rem = 0;
    else if (bus.i_hready && bus.i_htrans == 2'd2) n_rem = burst_beats(bus.i_hburst) - 1;
    else if (bus.i_hready && bus.i_htrans == 2'd3 && m_rem > 0) n_rem = m_rem - 1;
    open  = bus.i_hready && !m_lock && !bus.i_hlock[m_gnt] && (n_rem == 0);
    n_gnt = m_gnt; n_ptr = m_ptr; found = 1'b0;
    if (open) begin
      n_gnt = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && bus.i_hbusreq[c]) begin found = 1'b1; n_gnt = c; end
      end
      if (found && n_gnt != m_gnt) n_ptr = n_gnt;
    end
    n_hm = m_hm; n_hmd = m_hmd; n_lock = m_lock;
    if (bus.i_hready) begin n_hmd = m_hm; n_hm = m_gnt; n_lock = bus.i_hlock[m_gnt]; end
    @(posedge clk);
    #1;
    m_gnt = n_gnt; m_ptr = n_ptr; m_rem = n_rem; m_hm = n_hm; m_hmd = n_hmd; m_lock = n_lock;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.o_hgrant !== 4'b0001 || bus.o_hmaster !== 2'd0 || bus.o_hmaster_data !== 2'd0 || bus.o_hmastlock !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b hm=%0d hmd=%0d lk=%b exp gnt=0001 hm=0 hmd=0 lk=0",
               bus.o_hgrant, bus.o_hmaster, bus.o_hmaster_data, bus.o_hmastlock);
    end
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.o_hgrant !== 4'b0001 || bus.o_hmaster !== 2'd0 || bus.o_hmastlock !== 1'b0) begin
        errors++;
        $display("FAIL idle_default cyc %0d got gnt=%b hm=%0d lk=%b exp gnt=0001 hm=0 lk=0",
                 i, bus.o_hgrant, bus.o_hmaster, bus.o_hmastlock);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [4] = '{1, 2, 1, 2};
    drive(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.o_hgrant !== onehot(exp_seq[i])) begin
        errors++;
        $display("FAIL rr_grant cyc %0d got %b exp %b", i, bus.o_hgrant, onehot(exp_seq[i]));
      end
      checks++;
      if (bus.o_hmaster !== W'(m_hm) || bus.o_hmaster_data !== W'(m_hmd)) begin
        errors++;
        $display("FAIL rr_owner cyc %0d got hm=%0d hmd=%0d exp hm=%0d hmd=%0d",
                 i, bus.o_hmaster, bus.o_hmaster_data, m_hm, m_hmd);
      end
    end
  endtask

  task automatic test_burst();
    logic [1:0]   tr  [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    logic         rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] eg  [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 10 && !(m_gnt == 1 && m_hm == 1); i++) tick();
    checks++;
    if (bus.o_hgrant !== 4'b0010 || bus.o_hmaster !== 2'd1) begin
      errors++;
      $display("FAIL burst_setup got gnt=%b hm=%0d exp gnt=0010 hm=1", bus.o_hgrant, bus.o_hmaster);
    end
    for (int i = 0; i < 5; i++) begin
      drive(4'b1010, 4'b0000, tr[i], 3'd3, rdy[i], 2'd0);
      tick();
      checks++;
      if (bus.o_hgrant !== eg[i] || bus.o_hgrant !== onehot(m_gnt)) begin
        errors++;
        $display("FAIL burst_hold step %0d got %b exp %b", i, bus.o_hgrant, eg[i]);
      end
    end
  endtask

  task automatic test_lock();
    drive(4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 10 && !(m_gnt == 2 && m_hm == 2); i++) tick();
    checks++;
    if (bus.o_hgrant !== 4'b0100 || bus.o_hmaster !== 2'd2 || bus.o_hmastlock !== 1'b1) begin
      errors++;
      $display("FAIL lock_setup got gnt=%b hm=%0d lk=%b exp gnt=0100 hm=2 lk=1",
               bus.o_hgrant, bus.o_hmaster, bus.o_hmastlock);
    end
    for (int i = 0; i < 10; i++) begin
      drive(4'b0101, 4'b0100, 2'd2, 3'd0, 1'b1, 2'd0);
      tick();
      checks++;
      if (bus.o_hgrant !== 4'b0100 || bus.o_hmastlock !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold xfer %0d got gnt=%b lk=%b exp gnt=0100 lk=1", i, bus.o_hgrant, bus.o_hmastlock);
      end
    end
    drive(4'b0101, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    tick();
    checks++;
    if (bus.o_hgrant !== 4'b0100 || bus.o_hmastlock !== 1'b0) begin
      errors++;
      $display("FAIL lock_tail got gnt=%b lk=%b exp gnt=0100 lk=0", bus.o_hgrant, bus.o_hmastlock);
    end
    tick();
    checks++;
    if (bus.o_hgrant !== 4'b0001 || bus.o_hgrant !== onehot(m_gnt)) begin
      errors++;
      $display("FAIL lock_release got %b exp 0001", bus.o_hgrant);
    end
  endtask

  task automatic test_retry();
    logic [1:0]   tr  [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    logic         rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0]   rsp [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    logic [N-1:0] eg  [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 10 && !(m_gnt == 1 && m_hm == 1); i++) tick();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110, 4'b0000, tr[i], 3'd5, rdy[i], rsp[i]);
      tick();
      checks++;
      if (bus.o_hgrant !== eg[i] || bus.o_hgrant !== onehot(m_gnt)) begin
        errors++;
        $display("FAIL retry_grant step %0d got %b exp %b", i, bus.o_hgrant, eg[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 10 && !(m_gnt == 3 && m_hm == 3); i++) tick();
    drive(4'b1000, 4'b0000, 2'd2, 3'd7, 1'b1, 2'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1000, 4'b0000, 2'd3, 3'd7, 1'b1, 2'd0);
      tick();
    end
    checks++;
    if (bus.o_hgrant !== 4'b1000 || bus.o_hmaster !== 2'd3) begin
      errors++;
      $display("FAIL arst_setup got gnt=%b hm=%0d exp gnt=1000 hm=3", bus.o_hgrant, bus.o_hmaster);
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.o_hgrant !== 4'b0001 || bus.o_hmaster !== 2'd0 || bus.o_hmaster_data !== 2'd0 || bus.o_hmastlock !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got gnt=%b hm=%0d hmd=%0d lk=%b exp gnt=0001 hm=0 hmd=0 lk=0",
               bus.o_hgrant, bus.o_hmaster, bus.o_hmaster_data, bus.o_hmastlock);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_hgrant !== 4'b0001) begin
      errors++;
      $display("FAIL arst_held got %b exp 0001", bus.o_hgrant);
    end
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [N-1:0] lck;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) lck[b] = ($urandom_range(0, 3) == 0);
      drive(N'($urandom), lck, 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
      tick();
      checks++;
      if (bus.o_hgrant !== onehot(m_gnt)) begin
        errors++;
        $display("FAIL rand_grant cyc %0d got %b exp %b", i, bus.o_hgrant, onehot(m_gnt));
      end
      checks++;
      if (bus.o_hmaster !== W'(m_hm) || bus.o_hmaster_data !== W'(m_hmd) || bus.o_hmastlock !== m_lock) begin
        errors++;
        $display("FAIL rand_owner cyc %0d got hm=%0d hmd=%0d lk=%b exp hm=%0d hmd=%0d lk=%b",
                 i, bus.o_hmaster, bus.o_hmaster_data, bus.o_hmastlock, m_hm, m_hmd, m_lock);
      end
    end
  endtask

  initial begin
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_round_robin();
    test_burst();
    test_lock();
    test_retry();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Multi-master AHB bus arbiter that shares one AHB slave fabric between up to N ahb_master instances.
- Samples each master's o_hbusreq/o_hlock and drives back i_hgrant.
- Tracks the owner's fixed-length bursts so they are not broken mid-burst.
- Drives HMASTER/HMASTLOCK for the address and data phases, as the decoder and write-data/control muxes require.
- Sits between the masters and the slave muxes in the bench and SoC top.

Parameters:
N_MASTERS, 4, number of requesting masters (2..16).
DEF_MASTER, 0, default master index, granted when nobody requests.
MST_WDT, 2, width of master index; must equal clog2(N_MASTERS).

Ports:
i_hclk  in  1  bus clock; all state on rising edge.
i_hreset_n  in  1  asynchronous active-low reset.
i_hbusreq  in  N_MASTERS  per-master bus request.
i_hlock  in  N_MASTERS  per-master locked-transfer request.
i_htrans  in  2  HTRANS of the currently muxed (address-phase) master.
i_hburst  in  3  HBURST of the currently muxed master.
i_hready  in  1  HREADY from the slave mux.
i_hresp  in  2  HRESP from the slave mux.
o_hgrant  out  N_MASTERS  one-hot grant, registered.
o_hmaster  out  MST_WDT  owner of the current address phase.
o_hmaster_data  out  MST_WDT  owner of the current data phase (hwdata mux select).
o_hmastlock  out  1  current address phase is locked.

Behaviour:
- Reset values (async, when i_hreset_n=0):
  - o_hgrant = one-hot(DEF_MASTER)
  - o_hmaster = o_hmaster_data = DEF_MASTER
  - o_hmastlock = 0
  - beat counter = 0
  - round-robin pointer = DEF_MASTER
- Grant register gnt (index) drives o_hgrant combinationally as one-hot; gnt itself is a flop.
- Ownership transfer: on a rising edge with i_hready=1:
  - o_hmaster <= gnt
  - o_hmaster_data <= o_hmaster
  - o_hmastlock <= i_hlock[gnt]
  - With i_hready=0 all three hold.
- Beat counter (5 bits) tracks fixed bursts of the owner. An accepted beat is i_hready=1 and i_htrans is NONSEQ(2) or SEQ(3).
  - Accepted NONSEQ with i_hburst WRAP4/INCR4: load 3. WRAP8/INCR8: load 7. WRAP16/INCR16: load 15. SINGLE/INCR: load 0.
  - Accepted SEQ with counter>0: decrement.
  - IDLE(0) or BUSY(1): no change.
  - i_hresp ERROR(1), RETRY(2) or SPLIT(3) with i_hready=0 (first response cycle): clear counter to 0 on that edge.
- Handover window: re-arbitration is allowed on a rising edge only when all of the following hold:
  - i_hready=1
  - o_hmastlock=0 and i_hlock[gnt]=0
  - counter is 0, or counter is 1 and the current beat is an accepted SEQ (last address being accepted)
- Arbitration inside the window:
  - Round-robin: search indices pointer+1, pointer+2, ... (mod N_MASTERS) for the first i_hbusreq=1.
  - Current owner is included last, so it keeps the bus only if nobody else requests.
  - No requester: gnt <= DEF_MASTER.
  - Pointer <= new gnt whenever gnt changes to a requesting master.
- Outside the window: gnt holds, even if the owner drops i_hbusreq.
- Locked sequences:
  - While i_hlock[gnt]=1, the grant is held regardless of other requests.
  - After the owner deasserts hlock, the window reopens only after one further accepted transfer with o_hmastlock=1 has completed. This guarantees the final locked data phase.
- Simultaneous events:
  - Owner's last burst beat and a new request in the same cycle: grant moves on that edge.
  - Reset mid-burst: immediate return to reset values; the counter is discarded.
- SPLIT masking is out of scope: SPLIT is treated like RETRY (counter clear only).
- Latency:
  - Request to o_hgrant: 1 cycle when the window is open.
  - o_hgrant to o_hmaster: the next edge with i_hready=1.

Test Plan:
- Reset, no requests, hready=1 for 5 cycles -> o_hgrant=4'b0001, o_hmaster=0, o_hmastlock=0 throughout.
- Masters 1 and 2 both request continuously, SINGLE NONSEQ every cycle, hready=1 -> grant alternates 1,2,1,2; o_hmaster follows 1 cycle later; o_hmaster_data 1 cycle after that.
- Master 1 owns and issues INCR4 (NONSEQ + 3 SEQ) while master 3 requests from the NONSEQ cycle, with hready=0 on beat 2 -> o_hgrant stays 4'b0010 until the edge accepting SEQ #3, then 4'b1000.
- Master 2 holds hlock=1 for 10 transfers while master 0 requests -> grant stays 2. After hlock drops: one more transfer with o_hmastlock=1, then grant moves to 0.
- Master 1 in INCR8 receives RETRY (two cycles of hresp=2, hready 0 then 1) with master 2 requesting -> counter cleared, grant moves to 2 on the hready=1 edge.
- Assert i_hreset_n=0 asynchronously mid-INCR16 -> outputs return to reset values without waiting for a clock edge.
